// File: rtl/p10_frame_ctrl_if.sv
// p10_frame_ctrl_if: UART byte stream, scanner sync, display memory write port and display config of the P10 frame controller.
interface p10_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       scan_frame_end;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_bank;
    logic [3:0] bright;
    logic       display_en;
    logic       frame_ok;
    logic       err_chk;
    logic       err_cmd;
    logic       err_timeout;
    logic       led;
    modport master (
        input  rx_data, rx_data_valid, scan_frame_end,
        output rx_data_ready, wr_en, wr_addr, wr_data, rd_bank, bright, display_en,
               frame_ok, err_chk, err_cmd, err_timeout, led
    );
    modport slave (
        output rx_data, rx_data_valid, scan_frame_end,
        input  rx_data_ready, wr_en, wr_addr, wr_data, rd_bank, bright, display_en,
               frame_ok, err_chk, err_cmd, err_timeout, led
    );
endinterface

// File: rtl/p10_frame_ctrl.sv
// p10_frame_ctrl: packet parser and double-buffer bank scheduler for the P10 scanner.
// P10_FRAME_CRC8_EN selects a CRC-8 (poly 0x07) packet check instead of the XOR checksum.
module p10_frame_ctrl #(
    parameter int         FRAME_BYTES = 64,
    parameter int         TIMEOUT_CYC = 2000000,
    parameter logic [7:0] SYNC_BYTE   = 8'hAA
) (
    input logic              clk,
    input logic              rst,
    p10_frame_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, CMD, DATA, PARAM, CHKB, COMMIT, WAIT_SWAP} state_e;
    state_e      state_q;
    logic [7:0]  cmd_q, chk_q, chk_d, wr_data_q;
    logic [3:0]  param_q, bright_q;
    logic [5:0]  idx_q;
    logic [6:0]  wr_addr_q;
    logic [20:0] tmr_q;
    logic        wr_en_q, rd_bank_q, display_en_q, led_q;
    logic        frame_ok_q, err_chk_q, err_cmd_q, err_timeout_q;
    logic        acc, busy, tmo;
    assign bus.rx_data_ready = state_q != COMMIT && state_q != WAIT_SWAP;
    assign acc  = bus.rx_data_valid & bus.rx_data_ready;
    assign busy = state_q inside {CMD, DATA, PARAM, CHKB};
    assign tmo  = busy && !acc && tmr_q == 21'(TIMEOUT_CYC - 1);
`ifdef P10_FRAME_CRC8_EN
    always_comb begin
        chk_d = chk_q ^ bus.rx_data;
        for (int i = 0; i < 8; i++) chk_d = chk_d[7] ? {chk_d[6:0], 1'b0} ^ 8'h07 : {chk_d[6:0], 1'b0};
    end
`else
    assign chk_d = chk_q ^ bus.rx_data;
`endif
    always_ff @(posedge clk) begin
        wr_en_q       <= 1'b0;
        frame_ok_q    <= 1'b0;
        err_chk_q     <= 1'b0;
        err_cmd_q     <= 1'b0;
        err_timeout_q <= 1'b0;
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            chk_q        <= '0;
            param_q      <= '0;
            idx_q        <= '0;
            tmr_q        <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_bank_q    <= 1'b0;
            bright_q     <= 4'hF;
            display_en_q <= 1'b0;
            led_q        <= 1'b1;
        end else begin
            tmr_q <= (acc || !busy) ? 21'd0 : tmr_q + 21'd1;
            if (tmo) begin
                state_q       <= IDLE;
                err_timeout_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (acc && bus.rx_data == SYNC_BYTE) begin
                        state_q <= CMD;
                        chk_q   <= '0;
                    end
                    CMD: if (acc) begin
                        cmd_q     <= bus.rx_data;
                        chk_q     <= chk_d;
                        idx_q     <= '0;
                        state_q   <= bus.rx_data == 8'h01 ? DATA :
                                     bus.rx_data == 8'h02 ? PARAM :
                                     bus.rx_data == 8'h03 ? CHKB : IDLE;
                        err_cmd_q <= !(bus.rx_data inside {8'h01, 8'h02, 8'h03});
                    end
                    DATA: if (acc) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {~rd_bank_q, idx_q};
                        wr_data_q <= bus.rx_data;
                        chk_q     <= chk_d;
                        idx_q     <= idx_q + 6'd1;
                        if (idx_q == 6'(FRAME_BYTES - 1)) state_q <= CHKB;
                    end
                    PARAM: if (acc) begin
                        param_q <= bus.rx_data[3:0];
                        chk_q   <= chk_d;
                        state_q <= CHKB;
                    end
                    CHKB: if (acc) begin
                        state_q   <= bus.rx_data == chk_q ? COMMIT : IDLE;
                        err_chk_q <= bus.rx_data != chk_q;
                    end
                    COMMIT: begin
                        state_q <= cmd_q == 8'h01 ? WAIT_SWAP : IDLE;
                        if (cmd_q == 8'h02) bright_q <= param_q;
                        if (cmd_q == 8'h03) begin
                            display_en_q <= 1'b0;
                            led_q        <= 1'b1;
                        end
                    end
                    WAIT_SWAP: if (bus.scan_frame_end) begin
                        rd_bank_q    <= ~rd_bank_q;
                        display_en_q <= 1'b1;
                        led_q        <= 1'b0;
                        frame_ok_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.bright      = bright_q;
    assign bus.display_en  = display_en_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_cmd     = err_cmd_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.led         = led_q;
endmodule
